// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle for the 7-segment scan decoder: scanned display lines in,
// decoded word out on a valid/ready handshake, plus the sticky overrun flag.
interface seg7_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg_in;
   logic [NUM_DIGITS-1:0]   dig_en;
   logic [4*NUM_DIGITS-1:0] out_data;
   logic [NUM_DIGITS-1:0]   out_err;
   logic                    out_valid;
   logic                    out_ready;
   logic                    overrun;

   // Display source / word consumer side
   modport master (
      output seg_in, dig_en, out_ready,
      input  out_data, out_err, out_valid, overrun
   );

   // Decoder side
   modport slave (
      input  seg_in, dig_en, out_ready,
      output out_data, out_err, out_valid, overrun
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment display: samples the scanned
// segment lines and one-hot digit enables, waits for each digit's pattern to
// settle, decodes it back to a hex nibble and assembles one word per frame.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
)(
   input  logic                 clk,
   input  logic                 rst_n,
   seg7_scan_decoder_if.slave   bus
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   // Pattern -> {err, nibble}; unknown patterns decode to nibble 0 with err set
   function automatic logic [4:0] f_decode(input logic [6:0] seg);
      case (seg)
         7'b1111110: return 5'h00;
         7'b0110000: return 5'h01;
         7'b1101101: return 5'h02;
         7'b1111001: return 5'h03;
         7'b0110011: return 5'h04;
         7'b1011011: return 5'h05;
         7'b1011111: return 5'h06;
         7'b1110000: return 5'h07;
         7'b1111111: return 5'h08;
         7'b1111011: return 5'h09;
         7'b1110111: return 5'h0A;
         7'b0011111: return 5'h0B;
         7'b1001110: return 5'h0C;
         7'b0111101: return 5'h0D;
         7'b1001111: return 5'h0E;
         7'b1000111: return 5'h0F;
         default:    return 5'h10;
      endcase
   endfunction

   logic [6:0]              r_seg, r_seg_prev;
   logic [NUM_DIGITS-1:0]   r_dig, r_dig_prev;
   state_t                  r_state, w_state_next;
   logic [CW-1:0]           r_cnt, w_cnt_next;
   logic [NUM_DIGITS-1:0]   r_mask;
   logic [4*NUM_DIGITS-1:0] r_buf_data;
   logic [NUM_DIGITS-1:0]   r_buf_err;
   logic [4*NUM_DIGITS-1:0] r_out_data;
   logic [NUM_DIGITS-1:0]   r_out_err;
   logic                    r_out_valid;
   logic                    r_overrun;

   logic                    w_onehot;
   logic                    w_same;
   logic                    w_capture;
   logic                    w_frame_done;
   logic [4:0]              w_dec;

   assign w_onehot     = (r_dig != '0) && ((r_dig & (r_dig - 1'b1)) == '0);
   assign w_same       = (r_seg == r_seg_prev) && (r_dig == r_dig_prev);
   assign w_dec        = f_decode(r_seg);
   assign w_frame_done = &r_mask;

   // Sample stage, one-cycle history for stability compare, and FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_seg      <= '0;
         r_dig      <= '0;
         r_seg_prev <= '0;
         r_dig_prev <= '0;
         r_state    <= IDLE;
         r_cnt      <= '0;
      end else begin
         r_seg      <= bus.seg_in;
         r_dig      <= bus.dig_en;
         r_seg_prev <= r_seg;
         r_dig_prev <= r_dig;
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
      end
   end

   // Next-state: count consecutive identical samples of the current dwell
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      if (!w_onehot) begin
         w_state_next = IDLE;
         w_cnt_next   = '0;
      end else if (r_state == IDLE || !w_same) begin
         w_state_next = SETTLE;
         w_cnt_next   = CW'(1);
      end else if (r_state == SETTLE) begin
         w_cnt_next = r_cnt + CW'(1);
         if (w_cnt_next == CW'(STABLE_CYCLES)) begin
            w_state_next = HELD;
         end
      end
   end

   // Output decode: capture exactly on the SETTLE->HELD transition
   always_comb begin
      w_capture = (r_state == SETTLE) && (w_state_next == HELD);
   end

   // Frame buffer and capture mask; a completed mask clears as the word is handed on
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mask     <= '0;
         r_buf_data <= '0;
         r_buf_err  <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_capture && r_dig[i]) begin
               r_buf_data[4*i +: 4] <= w_dec[3:0];
               r_buf_err[i]         <= w_dec[4];
            end
         end
         r_mask <= (w_frame_done ? '0 : r_mask) | (w_capture ? r_dig : '0);
      end
   end

   // Output word register and valid/ready handshake; frames arriving while a word is stuck are dropped
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_err   <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else if (w_frame_done) begin
         if (!r_out_valid || bus.out_ready) begin
            r_out_data  <= r_buf_data;
            r_out_err   <= r_buf_err;
            r_out_valid <= 1'b1;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.out_data  = r_out_data;
   assign bus.out_err   = r_out_err;
   assign bus.out_valid = r_out_valid;
   assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder: directed scan sequences, a pin-level
// run-length model checked every cycle, and literal word/timing expectations.
module tb_seg7_scan_decoder;
   localparam int ND = 4;
   localparam int SC = 4;

   localparam logic [6:0] PAT [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state
   int          m_run;
   logic [10:0] m_last;
   logic        m_last_ok;
   logic        m_cap_pend;
   int          m_cap_dig;
   logic [3:0]  m_cap_nib;
   logic        m_cap_err;
   logic [3:0]  m_mask;
   logic [15:0] m_buf;
   logic [3:0]  m_buferr;
   logic        m_frame_pend;
   logic [15:0] m_data;
   logic [3:0]  m_err;
   logic        m_valid;
   logic        m_ovr;

   // Accepted-word log taken from the pins
   int          acc_n = 0;
   logic [15:0] acc_data;
   logic [3:0]  acc_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_last = '0; m_last_ok = 1'b0;
      m_cap_pend = 1'b0; m_cap_dig = 0; m_cap_nib = '0; m_cap_err = 1'b0;
      m_mask = '0; m_buf = '0; m_buferr = '0; m_frame_pend = 1'b0;
      m_data = '0; m_err = '0; m_valid = 1'b0; m_ovr = 1'b0;
   endtask

   // Advance the model by one clock edge using the pins present at that edge
   task automatic model_step();
      logic [3:0]  newmask;
      logic [10:0] pair;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_frame_pend) begin
         if (!m_valid || bus.out_ready) begin
            m_data = m_buf; m_err = m_buferr; m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_valid && bus.out_ready) begin
         m_valid = 1'b0;
      end
      newmask = m_frame_pend ? 4'b0000 : m_mask;
      if (m_cap_pend) begin
         m_buf[4*m_cap_dig +: 4] = m_cap_nib;
         m_buferr[m_cap_dig]     = m_cap_err;
         newmask[m_cap_dig]      = 1'b1;
      end
      m_mask       = newmask;
      m_frame_pend = (m_mask == 4'hF);
      // A pair held for SC consecutive edges is captured on the following edge
      pair = {bus.dig_en, bus.seg_in};
      if (m_last_ok && pair == m_last) m_run++;
      else m_run = 1;
      m_last    = pair;
      m_last_ok = 1'b1;
      m_cap_pend = ($countones(bus.dig_en) == 1) && (m_run == SC);
      if (m_cap_pend) begin
         for (int i = 0; i < ND; i++) if (bus.dig_en[i]) m_cap_dig = i;
         m_cap_nib = 4'h0;
         m_cap_err = 1'b1;
         for (int n = 0; n < 16; n++) begin
            if (PAT[n] == bus.seg_in) begin
               m_cap_nib = 4'(n);
               m_cap_err = 1'b0;
            end
         end
      end
   endtask

   // One clock: log handshakes, advance the model, compare all outputs after the edge
   task automatic tick();
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         acc_n++;
         acc_data = bus.out_data;
         acc_err  = bus.out_err;
      end
      @(posedge clk);
      model_step();
      #1;
      chk("out_data",  bus.out_data,  m_data);
      chk("out_err",   bus.out_err,   m_err);
      chk("out_valid", bus.out_valid, m_valid);
      chk("overrun",   bus.overrun,   m_ovr);
   endtask

   task automatic dwell(input logic [3:0] d, input logic [6:0] s, input int n);
      bus.dig_en = d;
      bus.seg_in = s;
      repeat (n) tick();
   endtask

   int acc0;

   initial begin
      model_reset();
      rst_n = 1'b0;
      bus.out_ready = 1'b1;
      bus.seg_in = '0;
      bus.dig_en = '0;

      // 1: reset with toggling inputs
      for (int i = 0; i < 3; i++) begin
         bus.seg_in = 7'($urandom);
         bus.dig_en = i[0] ? 4'b0001 : 4'b0110;
         tick();
      end
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_data",  bus.out_data,  16'h0000);
      chk("rst_ovr",   bus.overrun,   1'b0);
      rst_n = 1'b1;

      // 2: plain scan
      acc0 = acc_n;
      dwell(4'b0001, 7'b1111001, 8);
      dwell(4'b0010, 7'b0111101, 8);
      dwell(4'b0100, 7'b0110000, 8);
      dwell(4'b1000, 7'b1000111, 8);
      dwell(4'b0000, 7'b0000000, 2);
      chk("scan_pulses", acc_n - acc0, 1);
      chk("scan_word",   acc_data, 16'hF1D3);
      chk("scan_err",    acc_err,  4'b0000);

      // 3: glitch on the last digit; only the settled pattern counts
      dwell(4'b0001, PAT[2], 8);
      dwell(4'b0010, PAT[7], 8);
      dwell(4'b0100, PAT[14], 8);
      dwell(4'b1000, PAT[8], 3);
      bus.seg_in = PAT[5];
      repeat (5) tick();
      chk("glitch_early", bus.out_valid, 1'b0);
      tick();
      chk("glitch_land", bus.out_valid, 1'b1);
      chk("glitch_word", bus.out_data, 16'h5E72);
      dwell(4'b0000, 7'b0000000, 2);

      // 4: invalid pattern on digit 2
      acc0 = acc_n;
      dwell(4'b0001, PAT[0], 8);
      dwell(4'b0010, PAT[9], 8);
      dwell(4'b0100, 7'b0000001, 8);
      dwell(4'b1000, PAT[11], 8);
      dwell(4'b0000, 7'b0000000, 2);
      chk("inv_pulses", acc_n - acc0, 1);
      chk("inv_word",   acc_data, 16'hB090);
      chk("inv_err",    acc_err,  4'b0100);

      // 5: backpressure over two frames
      bus.out_ready = 1'b0;
      dwell(4'b0001, PAT[1], 8);
      dwell(4'b0010, PAT[2], 8);
      dwell(4'b0100, PAT[3], 8);
      dwell(4'b1000, PAT[4], 8);
      dwell(4'b0001, PAT[5], 8);
      dwell(4'b0010, PAT[6], 8);
      dwell(4'b0100, PAT[7], 8);
      dwell(4'b1000, PAT[8], 8);
      dwell(4'b0000, 7'b0000000, 2);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_word",  bus.out_data,  16'h4321);
      chk("bp_ovr",   bus.overrun,   1'b1);
      acc0 = acc_n;
      bus.out_ready = 1'b1;
      tick();
      chk("bp_fall",   bus.out_valid, 1'b0);
      chk("bp_accept", acc_n - acc0, 1);
      chk("bp_acc_word", acc_data, 16'h4321);

      // 6a: non-one-hot enables mid-frame leave the mask alone
      acc0 = acc_n;
      dwell(4'b0001, PAT[1], 8);
      dwell(4'b0010, PAT[2], 8);
      dwell(4'b0011, PAT[3], 10);
      dwell(4'b0000, PAT[4], 10);
      chk("noh_novalid", bus.out_valid, 1'b0);
      dwell(4'b0100, PAT[3], 8);
      dwell(4'b1000, PAT[4], 8);
      dwell(4'b0000, 7'b0000000, 2);
      chk("noh_pulses", acc_n - acc0, 1);
      chk("noh_word",   acc_data, 16'h4321);

      // 6b: reset after two digits discards them
      dwell(4'b0001, PAT[5], 8);
      dwell(4'b0010, PAT[6], 8);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      acc0 = acc_n;
      dwell(4'b0100, PAT[7], 8);
      dwell(4'b1000, PAT[8], 8);
      chk("rstmid_novalid", bus.out_valid, 1'b0);
      chk("rstmid_ovr",     bus.overrun,   1'b0);
      dwell(4'b0001, PAT[1], 8);
      dwell(4'b0010, PAT[2], 8);
      dwell(4'b0000, 7'b0000000, 2);
      chk("rstmid_pulses", acc_n - acc0, 1);
      chk("rstmid_word",   acc_data, 16'h8721);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
